tl_phase_monitor: RTL and testbench
===================================

TL_PHASE_MONITOR -- requirements
Module: tl_phase_monitor

Interface
REQ-001 SHALL have parameter C_CLK_FRQ, default 100_000_000, clock frequency [Hz].
REQ-002 SHALL have parameter C_TICK_CYC, default 100_000, clock cycles per measurement tick.
REQ-003 SHALL have parameter C_STABLE, default 16, clock cycles a new colour must persist before acceptance.
REQ-004 SHALL have parameters C_INT_RED/C_INT_GREEN/C_INT_YELLOW/C_INT_WALK, defaults 10/10/2/5, expected phase lengths [ticks].
REQ-005 SHALL have parameter C_TOL, default 1, allowed length deviation [ticks].
REQ-006 SHALL have parameter C_COLORS, default 12'b100_010_110_111, RGB codes for {RED,GREEN,YELLOW,WALK} (MSB group first).
REQ-007 sysClk  in  1  single clock; all logic on rising edge.
REQ-008 sysRst  in  1  asynchronous, active-high reset.
REQ-009 ledRGB  in  3  observed light {R,G,B}, asynchronous to sysClk.
REQ-010 phase  out  3  current accepted phase: 0 OFF, 1 RED, 2 GREEN, 3 YELLOW, 4 WALK, 7 INVALID.
REQ-011 phaseLen  out  16  length of last completed phase [ticks].
REQ-012 phaseStb  out  1  one-cycle strobe: phaseLen/errSeq/errLen valid.
REQ-013 errSeq  out  1  completed transition was illegal (valid with phaseStb).
REQ-014 errLen  out  1  completed phase length out of tolerance (valid with phaseStb).
REQ-015 errCnt  out  8  saturating count of errored phase completions.

Function
REQ-016 ledRGB SHALL pass a 2-flop synchroniser before any use.
REQ-017 Decoder SHALL map synchronised code to RED/GREEN/YELLOW/WALK by C_COLORS, 3'b000 to OFF, anything else to INVALID.
REQ-018 Candidate colour SHALL become accepted only after C_STABLE consecutive identical samples; shorter pulses SHALL be ignored entirely.
REQ-019 Prescaler SHALL emit one tick every C_TICK_CYC cycles, free-running from reset.
REQ-020 Length counter SHALL increment per tick, saturate at 16'hFFFF, and reset to 0 on every accepted phase change.
REQ-021 OFF accepted for fewer than 2 ticks between two identical non-OFF phases SHALL be treated as blink: no phase completion, length counter continues.
REQ-022 On accepted change A->B (A not OFF, not a blink gap), phaseStb SHALL assert exactly one cycle after acceptance, phaseLen = A's final count.
REQ-023 Legal transitions: GREEN->YELLOW, YELLOW->RED, RED->GREEN, RED->WALK, WALK->RED, any->OFF, OFF->any non-INVALID; all others SHALL set errSeq.
REQ-024 errLen SHALL set when A in {RED,GREEN,YELLOW,WALK} and |phaseLen - C_INT_A| > C_TOL; never for OFF/INVALID.
REQ-025 errCnt SHALL increment by 1 per phaseStb with errSeq or errLen (once if both) and hold at 8'hFF.
REQ-026 FSM states: S_IDLE (no phase seen), S_RUN (phase active), S_GAP (OFF, blink window open); S_IDLE->S_RUN on first non-OFF acceptance without strobe; S_RUN->S_GAP on OFF; S_GAP->S_RUN same colour within window; S_GAP->S_RUN otherwise with completion of A.
REQ-027 Tick and acceptance in same cycle: acceptance takes priority; tick counts toward the new phase.

Reset
REQ-028 While sysRst high: phase=0, phaseLen=0, phaseStb=0, errSeq=0, errLen=0, errCnt=0, FSM S_IDLE, prescaler/filter/synchroniser cleared.
REQ-029 Reset mid-phase SHALL discard the phase silently; no strobe on release.

Structure
REQ-030 Phase enum, state enum, and decode function SHALL reside in package tl_pkg, shared with the traffic light design.
REQ-031 Synchroniser plus C_STABLE filter SHALL be sub-module tl_colour_filter.

Verification (C_TICK_CYC=100, C_STABLE=16)
REQ-032 RED 10 ticks -> GREEN: phaseStb once, phaseLen=10, errSeq=0, errLen=0, errCnt=0.
REQ-033 GREEN -> RED directly: errSeq=1, errCnt=1.
REQ-034 YELLOW 5 ticks -> RED: errLen=1, errSeq=0, errCnt=1.
REQ-035 8-cycle glitch of 3'b010 inside RED: phase stays 1, no strobe.
REQ-036 YELLOW with 1-tick OFF gaps for 2 ticks total on-time: no strobe until RED; then phaseLen counts gaps.
REQ-037 sysRst pulsed mid-GREEN: all outputs 0 immediately, no strobe after release, errCnt=0.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light design and its phase monitor.
//   phase_e       : accepted light phase (OFF/RED/GREEN/YELLOW/WALK/INVALID)
//   state_e       : phase-monitor tracking state
//   BLINK_TICKS   : an OFF shorter than this many ticks between identical
//                   phases is a blink, not a phase boundary
//   decode_colour : raw {R,G,B} code -> phase_e using a packed colour table
//   legal_step    : whether a single phase-to-phase step is an allowed sequence
package tl_pkg;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_RED     = 3'd1,
    PH_GREEN   = 3'd2,
    PH_YELLOW  = 3'd3,
    PH_WALK    = 3'd4,
    PH_INVALID = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_e;

  localparam int unsigned BLINK_TICKS = 2;

  // colors packs {RED,GREEN,YELLOW,WALK}, RED in the top three bits.
  function automatic phase_e decode_colour(input logic [11:0] colors,
                                           input logic [2:0]  code);
    phase_e ph;
    if (code == colors[11:9])      ph = PH_RED;
    else if (code == colors[8:6])  ph = PH_GREEN;
    else if (code == colors[5:3])  ph = PH_YELLOW;
    else if (code == colors[2:0])  ph = PH_WALK;
    else if (code == 3'b000)       ph = PH_OFF;
    else                           ph = PH_INVALID;
    return ph;
  endfunction

  function automatic logic legal_step(input phase_e a, input phase_e b);
    logic ok;
    ok = 1'b0;
    if (b == PH_OFF) begin
      ok = 1'b1;
    end else if (a == PH_OFF) begin
      ok = (b != PH_INVALID);
    end else begin
      case (a)
        PH_GREEN:  ok = (b == PH_YELLOW);
        PH_YELLOW: ok = (b == PH_RED);
        PH_RED:    ok = (b == PH_GREEN) || (b == PH_WALK);
        PH_WALK:   ok = (b == PH_RED);
        default:   ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/tl_colour_filter.sv
// Synchronises the asynchronous light code, decodes it and accepts a new
// colour only after C_STABLE consecutive identical samples.
//   clk, rst  : clock, asynchronous active-high reset
//   led_rgb   : raw {R,G,B} light code (asynchronous)
//   acc_phase : currently accepted phase
//   acc_chg   : one-cycle pulse, coincident with the first cycle of a new acc_phase
module tl_colour_filter
  import tl_pkg::*;
#(
  parameter int unsigned C_STABLE = 16,
  parameter logic [11:0] C_COLORS = 12'b100_010_110_111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] led_rgb,
  output phase_e     acc_phase,
  output logic       acc_chg
);

  localparam int unsigned CW = $clog2(C_STABLE + 1);

  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  phase_e        sample;
  phase_e        cand_q, cand_d;
  phase_e        acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, chg_d;

  always_comb begin
    sync1_d = led_rgb;
    sync2_d = sync1_q;
    sample  = decode_colour(C_COLORS, sync2_q);
    cand_d  = sample;
    // Run length of identical samples, saturating once the candidate qualifies.
    if (sample == cand_q) begin
      cnt_d = (cnt_q == CW'(C_STABLE)) ? cnt_q : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end
    acc_d = acc_q;
    chg_d = 1'b0;
    if ((cnt_d == CW'(C_STABLE)) && (cand_d != acc_q)) begin
      acc_d = cand_d;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= PH_OFF;
      cnt_q   <= '0;
      acc_q   <= PH_OFF;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      chg_q   <= chg_d;
    end
  end

  assign acc_phase = acc_q;
  assign acc_chg   = chg_q;

endmodule

// File: rtl/tl_phase_monitor.sv
// Traffic-light phase monitor: measures the length of every accepted light
// phase in prescaler ticks and flags illegal sequences and out-of-tolerance
// lengths.
//   sysClk, sysRst : clock, asynchronous active-high reset
//   ledRGB         : observed {R,G,B} light (asynchronous)
//   phase          : current accepted phase
//   phaseLen       : length of last completed phase [ticks]
//   phaseStb       : one-cycle strobe, phaseLen/errSeq/errLen valid
//   errSeq, errLen : sequence / length error of the completed phase
//   errCnt         : saturating count of errored completions
module tl_phase_monitor
  import tl_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ    = 100_000_000,
  parameter int unsigned C_TICK_CYC   = 100_000,
  parameter int unsigned C_STABLE     = 16,
  parameter int unsigned C_INT_RED    = 10,
  parameter int unsigned C_INT_GREEN  = 10,
  parameter int unsigned C_INT_YELLOW = 2,
  parameter int unsigned C_INT_WALK   = 5,
  parameter int unsigned C_TOL        = 1,
  parameter logic [11:0] C_COLORS     = 12'b100_010_110_111
) (
  input  logic        sysClk,
  input  logic        sysRst,
  input  logic [2:0]  ledRGB,
  output logic [2:0]  phase,
  output logic [15:0] phaseLen,
  output logic        phaseStb,
  output logic        errSeq,
  output logic        errLen,
  output logic [7:0]  errCnt
);

  // A zero tick period is meaningless; fall back to a 1 ms tick.
  localparam int unsigned TICK_CYC = (C_TICK_CYC == 0) ? (C_CLK_FRQ / 1000) : C_TICK_CYC;
  localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  phase_e        new_ph;
  logic          chg;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  state_e        state_q, state_d;
  phase_e        cur_q, cur_d;
  logic [15:0]   len_q, len_d, len_inc, fresh_len;
  logic [15:0]   snap_q, snap_d;
  logic [1:0]    gap_q, gap_d;
  logic [15:0]   plen_q, plen_d;
  logic          stb_q, stb_d, eseq_q, eseq_d, elen_q, elen_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          done, done_seq, done_elen;
  logic [15:0]   done_len;

  tl_colour_filter #(
    .C_STABLE (C_STABLE),
    .C_COLORS (C_COLORS)
  ) u_filter (
    .clk       (sysClk),
    .rst       (sysRst),
    .led_rgb   (ledRGB),
    .acc_phase (new_ph),
    .acc_chg   (chg)
  );

  function automatic logic len_bad(input phase_e a, input logic [15:0] l);
    int unsigned exp_len, got, dev;
    logic        bad;
    got = 32'(l);
    bad = 1'b0;
    case (a)
      PH_RED:    exp_len = C_INT_RED;
      PH_GREEN:  exp_len = C_INT_GREEN;
      PH_YELLOW: exp_len = C_INT_YELLOW;
      PH_WALK:   exp_len = C_INT_WALK;
      default:   exp_len = 0;
    endcase
    dev = (got > exp_len) ? got - exp_len : exp_len - got;
    if (a inside {PH_RED, PH_GREEN, PH_YELLOW, PH_WALK}) bad = (dev > C_TOL);
    return bad;
  endfunction

  always_comb begin
    tick    = (presc_q == PW'(TICK_CYC - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    len_inc   = (tick && (len_q != '1)) ? len_q + 16'd1 : len_q;
    // A tick coinciding with an acceptance belongs to the new phase.
    fresh_len = tick ? 16'd1 : 16'd0;

    state_d  = state_q;
    cur_d    = cur_q;
    len_d    = len_inc;
    snap_d   = snap_q;
    gap_d    = (tick && (gap_q != 2'(BLINK_TICKS))) ? gap_q + 2'd1 : gap_q;
    done     = 1'b0;
    done_len = len_q;
    done_seq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (chg && (new_ph != PH_OFF)) begin
          state_d = S_RUN;
          cur_d   = new_ph;
          len_d   = fresh_len;
        end
      end
      S_RUN: begin
        if (chg) begin
          if (new_ph == PH_OFF) begin
            // Keep counting through the OFF so a blink is seamless; remember
            // the length at the OFF edge in case it turns out to be a boundary.
            state_d = S_GAP;
            snap_d  = len_q;
            gap_d   = tick ? 2'd1 : 2'd0;
          end else begin
            done     = 1'b1;
            done_len = len_q;
            done_seq = !legal_step(cur_q, new_ph);
            cur_d    = new_ph;
            len_d    = fresh_len;
          end
        end
      end
      S_GAP: begin
        if (chg) begin
          state_d = S_RUN;
          if (!((new_ph == cur_q) && (gap_q < 2'(BLINK_TICKS)))) begin
            // Real boundary: the sequence was A->OFF->B, and A->OFF is always
            // legal, so only the OFF->B step can be an error.
            done     = 1'b1;
            done_len = snap_q;
            done_seq = !legal_step(PH_OFF, new_ph);
            cur_d    = new_ph;
            len_d    = fresh_len;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_elen = done && len_bad(cur_q, done_len);
    stb_d     = done;
    plen_d    = done ? done_len  : plen_q;
    eseq_d    = done ? done_seq  : eseq_q;
    elen_d    = done ? done_elen : elen_q;
    ecnt_d    = (done && (done_seq || done_elen) && (ecnt_q != '1)) ? ecnt_q + 8'd1 : ecnt_q;
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      presc_q <= '0;
      state_q <= S_IDLE;
      cur_q   <= PH_OFF;
      len_q   <= '0;
      snap_q  <= '0;
      gap_q   <= '0;
      plen_q  <= '0;
      stb_q   <= 1'b0;
      eseq_q  <= 1'b0;
      elen_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      snap_q  <= snap_d;
      gap_q   <= gap_d;
      plen_q  <= plen_d;
      stb_q   <= stb_d;
      eseq_q  <= eseq_d;
      elen_q  <= elen_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign phase    = new_ph;
  assign phaseLen = plen_q;
  assign phaseStb = stb_q;
  assign errSeq   = eseq_q;
  assign errLen   = elen_q;
  assign errCnt   = ecnt_q;

endmodule

// File: tb/tb_tl_phase_monitor.sv
// Bench for tl_phase_monitor: directed scenarios with literal expectations
// plus randomized light sequences, all checked every cycle against a
// sample-history reference model.
module tb_tl_phase_monitor;

  localparam int TICK = 100;
  localparam int STB  = 16;

  localparam int OFF = 0, RED = 1, GRN = 2, YEL = 3, WLK = 4, INV = 7;
  localparam logic [2:0] K_OFF = 3'b000, K_RED = 3'b100, K_GRN = 3'b010,
                         K_YEL = 3'b110, K_WLK = 3'b111;

  logic        sysClk = 1'b0;
  logic        sysRst;
  logic [2:0]  ledRGB;
  logic [2:0]  phase;
  logic [15:0] phaseLen;
  logic        phaseStb, errSeq, errLen;
  logic [7:0]  errCnt;

  tl_phase_monitor #(
    .C_TICK_CYC (TICK),
    .C_STABLE   (STB)
  ) dut (
    .sysClk   (sysClk),
    .sysRst   (sysRst),
    .ledRGB   (ledRGB),
    .phase    (phase),
    .phaseLen (phaseLen),
    .phaseStb (phaseStb),
    .errSeq   (errSeq),
    .errLen   (errLen),
    .errCnt   (errCnt)
  );

  always #5 sysClk = ~sysClk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int len; int seq; int elen; int cnt; } stb_t;
  stb_t slog[$];  // strobes seen on the DUT
  stb_t mlog[$];  // strobes produced by the model

  function automatic int colour_of(input logic [2:0] c);
    case (c)
      K_RED:   return RED;
      K_GRN:   return GRN;
      K_YEL:   return YEL;
      K_WLK:   return WLK;
      K_OFF:   return OFF;
      default: return INV;
    endcase
  endfunction

  function automatic int nominal(input int p);
    case (p)
      RED:     return 10;
      GRN:     return 10;
      YEL:     return 2;
      WLK:     return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit step_ok(input int a, input int b);
    if (b == OFF) return 1'b1;
    if (a == OFF) return b != INV;
    return (a * 8 + b) inside {RED*8+GRN, RED*8+WLK, GRN*8+YEL, YEL*8+RED, WLK*8+RED};
  endfunction

  // ---------------- reference model ----------------
  int unsigned n;
  int  synq[$];
  int  win[$];
  int  acc, pend_ph, a_ph, a_len, off_len, gap_ticks;
  bit  pend, started, in_gap;
  int  e_phase = 0, e_len = 0, e_cnt = 0;
  bit  e_stb = 0, e_seq = 0, e_elen = 0;

  always @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      n = 0; synq = '{0, 0}; win.delete();
      acc = OFF; pend = 0; pend_ph = OFF; started = 0; in_gap = 0;
      a_ph = OFF; a_len = 0; off_len = 0; gap_ticks = 0;
      e_phase = 0; e_len = 0; e_cnt = 0; e_stb = 0; e_seq = 0; e_elen = 0;
    end else begin
      int  tk, smp, L;
      bit  eq, seq;
      tk = ((n % TICK) == TICK - 1) ? 1 : 0;
      n++;
      e_stb = 0;
      // a phase accepted on the previous edge is acted upon now
      if (pend) begin
        if (!started) begin
          if (pend_ph != OFF) begin started = 1; a_ph = pend_ph; a_len = tk; end
        end else if (pend_ph == OFF) begin
          in_gap = 1; off_len = a_len; gap_ticks = tk; a_len += tk;
        end else if (in_gap && pend_ph == a_ph && gap_ticks < 2) begin
          in_gap = 0; a_len += tk;
        end else begin
          L   = in_gap ? off_len : a_len;
          seq = in_gap ? !(step_ok(a_ph, OFF) && step_ok(OFF, pend_ph)) : !step_ok(a_ph, pend_ph);
          e_stb  = 1;
          e_len  = L;
          e_seq  = seq;
          e_elen = (a_ph >= RED && a_ph <= WLK) &&
                   (((L > nominal(a_ph)) ? L - nominal(a_ph) : nominal(a_ph) - L) > 1);
          if ((e_seq || e_elen) && e_cnt < 255) e_cnt++;
          mlog.push_back('{e_len, int'(e_seq), int'(e_elen), e_cnt});
          a_ph = pend_ph; a_len = tk; in_gap = 0;
        end
      end else if (started) begin
        a_len = (a_len + tk > 65535) ? 65535 : a_len + tk;
        if (in_gap) gap_ticks += tk;
      end
      // two-stage synchroniser delay, then the last STB samples must agree
      synq.push_back(int'(ledRGB));
      smp = colour_of(3'(synq.pop_front()));
      win.push_back(smp);
      if (win.size() > STB) void'(win.pop_front());
      pend = 0;
      eq = (win.size() == STB);
      foreach (win[i]) if (win[i] != smp) eq = 0;
      if (eq && smp != acc) begin acc = smp; pend = 1; pend_ph = smp; end
      e_phase = acc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sysClk) begin
    n_cmp++;
    if (phase !== 3'(e_phase) || phaseLen !== 16'(e_len) || phaseStb !== e_stb ||
        errSeq !== e_seq || errLen !== e_elen || errCnt !== 8'(e_cnt)) begin
      n_bad++;
      $display("FAIL outputs @%0t got/want: phase=%0d/%0d len=%0d/%0d stb=%0b/%0b seq=%0b/%0b elen=%0b/%0b cnt=%0d/%0d",
               $time, phase, e_phase, phaseLen, e_len, phaseStb, e_stb, errSeq, e_seq,
               errLen, e_elen, errCnt, e_cnt);
    end
    if (phaseStb === 1'b1) slog.push_back('{int'(phaseLen), int'(errSeq), int'(errLen), int'(errCnt)});
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic hold(input logic [2:0] c, input int cyc);
    ledRGB = c;
    repeat (cyc) @(negedge sysClk);
  endtask

  task automatic expect_stb(input string nm, input int len, input int seq, input int elen, input int cnt);
    stb_t d, m;
    chk({nm, " dut_strobes"}, slog.size(), 1);
    chk({nm, " model_strobes"}, mlog.size(), 1);
    if (slog.size() > 0) begin
      d = slog.pop_front();
      chk({nm, " len"}, d.len, len);
      chk({nm, " errSeq"}, d.seq, seq);
      chk({nm, " errLen"}, d.elen, elen);
      chk({nm, " errCnt"}, d.cnt, cnt);
    end
    if (mlog.size() > 0) begin
      m = mlog.pop_front();
      chk({nm, " model_len"}, m.len, len);
      chk({nm, " model_errSeq"}, m.seq, seq);
      chk({nm, " model_errLen"}, m.elen, elen);
      chk({nm, " model_errCnt"}, m.cnt, cnt);
    end
    slog.delete();
    mlog.delete();
  endtask

  task automatic expect_none(input string nm);
    chk({nm, " dut_strobes"}, slog.size(), 0);
    chk({nm, " model_strobes"}, mlog.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] code, last;
    int kind, dur, p;
    sysRst = 1'b1;
    ledRGB = K_OFF;
    repeat (3) @(posedge sysClk);
    #1;
    chk("reset phase", int'(phase), 0);
    chk("reset phaseLen", int'(phaseLen), 0);
    chk("reset phaseStb", int'(phaseStb), 0);
    chk("reset errCnt", int'(errCnt), 0);
    #1 sysRst = 1'b0;
    @(negedge sysClk);

    // RED 10 ticks -> GREEN, then GREEN -> RED directly
    hold(K_OFF, 40);
    hold(K_RED, 1000);
    hold(K_GRN, 30);
    expect_stb("red_to_green", 10, 0, 0, 0);
    hold(K_GRN, 970);
    hold(K_RED, 30);
    expect_stb("green_to_red", 10, 1, 0, 1);

    // 8-cycle GREEN glitch inside RED
    hold(K_RED, 462);
    hold(K_GRN, 8);
    hold(K_RED, 40);
    chk("glitch phase", int'(phase), 1);
    expect_none("glitch");
    hold(K_RED, 460);
    hold(K_GRN, 30);
    expect_stb("red_glitched", 10, 0, 0, 1);
    hold(K_GRN, 970);
    hold(K_YEL, 30);
    expect_stb("green_to_yellow", 10, 0, 0, 1);

    // YELLOW 5 ticks -> RED: too long
    hold(K_YEL, 470);
    hold(K_RED, 30);
    expect_stb("yellow_long", 5, 0, 1, 2);

    // blinking YELLOW: 1 tick on, 1 tick off, 1 tick on
    hold(K_RED, 970);
    hold(K_GRN, 30);
    expect_stb("red_ok", 10, 0, 0, 2);
    hold(K_GRN, 970);
    hold(K_YEL, 30);
    expect_stb("green_ok", 10, 0, 0, 2);
    hold(K_YEL, 70);
    hold(K_OFF, 100);
    hold(K_YEL, 100);
    expect_none("blink");
    hold(K_RED, 30);
    expect_stb("blink_yellow", 3, 0, 0, 2);

    // reset mid-GREEN
    hold(K_RED, 970);
    hold(K_GRN, 30);
    expect_stb("red_before_rst", 10, 0, 0, 2);
    hold(K_GRN, 470);
    @(posedge sysClk);
    #2 sysRst = 1'b1;
    #1;
    chk("rst phase", int'(phase), 0);
    chk("rst phaseLen", int'(phaseLen), 0);
    chk("rst phaseStb", int'(phaseStb), 0);
    chk("rst errSeq", int'(errSeq), 0);
    chk("rst errLen", int'(errLen), 0);
    chk("rst errCnt", int'(errCnt), 0);
    repeat (5) @(posedge sysClk);
    #2 sysRst = 1'b0;
    slog.delete();
    mlog.delete();
    @(negedge sysClk);
    hold(K_GRN, 300);
    expect_none("after_reset");
    chk("after_reset errCnt", int'(errCnt), 0);
    chk("after_reset phase", int'(phase), 2);

    // randomized sequences
    last = K_GRN;
    for (int s = 0; s < 60; s++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: begin
          code = 3'($urandom_range(0, 7));
          hold(code, int'($urandom_range(1, 15)));
        end
        1: hold(K_OFF, int'($urandom_range(60, 199)));
        2: hold(K_OFF, int'($urandom_range(200, 400)));
        3: begin
          code = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011;
          hold(code, int'($urandom_range(50, 300)));
        end
        default: begin
          if ($urandom_range(0, 9) < 7) begin
            case (last)
              K_GRN:   code = K_YEL;
              K_YEL:   code = K_RED;
              K_WLK:   code = K_RED;
              default: code = ($urandom_range(0, 1) == 0) ? K_GRN : K_WLK;
            endcase
          end else begin
            case ($urandom_range(0, 3))
              0:       code = K_RED;
              1:       code = K_GRN;
              2:       code = K_YEL;
              default: code = K_WLK;
            endcase
          end
          p   = colour_of(code);
          dur = nominal(p) * TICK + int'($urandom_range(0, 250)) - 120;
          if (dur < 20) dur = 20;
          last = code;
          hold(code, dur);
        end
      endcase
    end
    hold(K_OFF, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
